dr_sync_sink: RTL

- Consumer stage sitting directly downstream of the dual-rail four-phase Fibonacci generator (fib_fp).
- Detects completion of each dual-rail codeword on `in` and synchronises it into the `clk` domain.
- Captures the decoded single-rail word into a small FIFO and returns the four-phase acknowledge on `ack_o`, which drives the generator's `ack_i`.
- The FIFO is drained by a synchronous valid/ready consumer.

---
 rtl/dr_sync_sink.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/dr_sync_sink.sv
// Dual-rail four-phase sink: completion detect, synchronise into clk, buffer in a FIFO.
// Optional illegal-codeword monitor enabled by defining DR_SYNC_SINK_ERR_CHECK_EN.
module dr_sync_sink #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0][1:0]       in,
  output logic                        ack_o,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(DEPTH):0]      level
`ifdef DR_SYNC_SINK_ERR_CHECK_EN
  ,
  output logic                        err,
  output logic [7:0]                  err_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {
    S_WAIT_VALID = 1'b0,
    S_WAIT_NULL  = 1'b1
  } state_t;

  logic                   all_valid, all_null;
  logic [WIDTH-1:0]       dec_data;
  logic [SYNC_STAGES-1:0] vsync_q, vsync_d, nsync_q, nsync_d;
  logic                   valid_s, null_s;
  state_t                 state_q, state_d;
  logic                   push, pop;
  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          count_q, count_d;
  logic [WIDTH-1:0]       out_data_q, out_data_d;

  // Completion detect: illegal 11 is neither valid nor null, so the FSM holds.
  always_comb begin
    all_valid = 1'b1;
    all_null  = 1'b1;
    dec_data  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      all_valid   = all_valid & (in[i][1] ^ in[i][0]);
      all_null    = all_null & ~(in[i][1] | in[i][0]);
      dec_data[i] = in[i][1];
    end
  end

  always_comb begin
    vsync_d = {vsync_q[SYNC_STAGES-2:0], all_valid};
    nsync_d = {nsync_q[SYNC_STAGES-2:0], all_null};
  end

  assign valid_s = vsync_q[SYNC_STAGES-1];
  assign null_s  = nsync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q <= '0;
      nsync_q <= '0;
    end else begin
      vsync_q <= vsync_d;
      nsync_q <= nsync_d;
    end
  end

  // Handshake FSM; the state bit is the acknowledge itself.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      S_WAIT_VALID: begin
        if (valid_s && (count_q != LW'(DEPTH))) begin
          push    = 1'b1;
          state_d = S_WAIT_NULL;
        end
      end
      S_WAIT_NULL: begin
        if (null_s) state_d = S_WAIT_VALID;
      end
      default: state_d = S_WAIT_VALID;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_WAIT_VALID;
    else     state_q <= state_d;
  end

  assign ack_o = (state_q == S_WAIT_NULL);

  // FIFO bookkeeping; a push at full is judged on the pre-pop count.
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + LW'(push) - LW'(pop);
    out_data_d = out_data_q;
    if (count_d != '0) begin
      if (push && (wr_ptr_q == rd_ptr_d)) out_data_d = dec_data;
      else                                out_data_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dec_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_data = out_data_q;
  assign level    = count_q;

`ifdef DR_SYNC_SINK_ERR_CHECK_EN
  logic                   any_illegal, illegal_s;
  logic [SYNC_STAGES-1:0] isync_q, isync_d;
  logic                   illegal_prev_q, illegal_prev_d;
  logic                   err_q, err_d;
  logic [7:0]             err_cnt_q, err_cnt_d;

  always_comb begin
    any_illegal = 1'b0;
    for (int i = 0; i < WIDTH; i++) any_illegal = any_illegal | (in[i][1] & in[i][0]);
  end

  assign illegal_s = isync_q[SYNC_STAGES-1];

  // Sticky flag plus saturating count of synchronised illegal episodes.
  always_comb begin
    isync_d        = {isync_q[SYNC_STAGES-2:0], any_illegal};
    illegal_prev_d = illegal_s;
    err_d          = err_q | illegal_s;
    err_cnt_d      = err_cnt_q;
    if (illegal_s && !illegal_prev_q && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      isync_q        <= '0;
      illegal_prev_q <= 1'b0;
      err_q          <= 1'b0;
      err_cnt_q      <= '0;
    end else begin
      isync_q        <= isync_d;
      illegal_prev_q <= illegal_prev_d;
      err_q          <= err_d;
      err_cnt_q      <= err_cnt_d;
    end
  end

  assign err     = err_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule
